// File: rtl/sopu_pkg.sv
// Shared constants, pixel type and a small helper for the image window block.
package sopu_pkg;

    localparam int DEF_KSIZE = 7;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

    // Address/counter width for a range of 'depth' values; never narrower than one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_image_window_line_buffer.sv
// One image line of pixel storage. The read port is registered; the caller
// presents the address it will need on the next cycle so data is ready in time.
module line_buffer
    import sopu_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int WIDTH = DEF_PIX_W,
    localparam int AW   = addr_bits(DEPTH)
)(
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write the new column value and read the prefetch address (old data on a collision).
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_image_window.sv
// Sliding KSIZE x KSIZE window generator over a raster pixel stream, with a
// single registered output stage toward the downstream convolution block.
module param_image_window
    import sopu_pkg::*;
#(
    parameter int KSIZE = DEF_KSIZE,
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [PIX_W-1:0]             pix_data,
    input  logic                         pix_sof,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [KSIZE*KSIZE*PIX_W-1:0] win_data,
    output logic                         frame_done
);

    localparam int CW  = addr_bits(IMG_W);
    localparam int RW  = addr_bits(IMG_H);
    localparam int NLB = KSIZE - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KSIZE - 1);

    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic             r_win_valid;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_lb_we;
    logic [RW-1:0]    w_row_eff;
    logic [RW-1:0]    w_row_next;
    logic [CW-1:0]    w_col_eff;
    logic [CW-1:0]    w_col_next;
    logic [CW-1:0]    w_rd_addr;
    logic             w_win_hit;
    logic             w_last_pix;
    logic [PIX_W-1:0] w_lb_rd [NLB];

    assign pix_ready  = !r_win_valid || win_ready;
    assign w_accept   = pix_valid && pix_ready;
    assign w_lb_we    = w_accept && !rst;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

    // Effective position of the offered pixel (sof forces 0,0), its successor, and the line-buffer prefetch address.
    always_comb begin
        w_row_eff  = pix_sof ? '0 : r_row;
        w_col_eff  = pix_sof ? '0 : r_col;
        w_last_pix = (w_row_eff == ROW_LAST) && (w_col_eff == COL_LAST);
        w_win_hit  = (w_row_eff >= ROW_FIRST) && (w_col_eff >= COL_FIRST);
        if (w_col_eff == COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_row_eff == ROW_LAST) ? '0 : w_row_eff + RW'(1);
        end else begin
            w_col_next = w_col_eff + CW'(1);
            w_row_next = w_row_eff;
        end
        // The column needed next cycle: after reset it is 0, after an accept the successor, otherwise unchanged.
        if (rst) begin
            w_rd_addr = '0;
        end else if (w_accept) begin
            w_rd_addr = w_col_next;
        end else begin
            w_rd_addr = r_col;
        end
    end

    // Position counters, output-stage valid and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last_pix;
            if (w_accept) begin
                r_row       <= w_row_next;
                r_col       <= w_col_next;
                r_win_valid <= w_win_hit;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    // Chain of line buffers: buffer 0 holds the previous row, buffer k the row k+1 lines back.
    genvar gi;
    generate
        for (gi = 0; gi < NLB; gi++) begin : g_lb
            logic [PIX_W-1:0] w_wr_data;
            if (gi == 0) begin : g_head
                assign w_wr_data = pix_data;
            end else begin : g_tail
                assign w_wr_data = w_lb_rd[gi-1];
            end
            line_buffer #(
                .DEPTH (IMG_W),
                .WIDTH (PIX_W)
            ) u_lb (
                .clk       (clk),
                .i_wr_en   (w_lb_we),
                .i_wr_addr (w_col_eff),
                .i_wr_data (w_wr_data),
                .i_rd_addr (w_rd_addr),
                .o_rd_data (w_lb_rd[gi])
            );
        end
    endgenerate

    // Window registers: each row shifts left on accept; the newest row takes the live pixel,
    // older rows take the matching line-buffer output for the same column.
    genvar gj;
    generate
        for (gi = 0; gi < KSIZE; gi++) begin : g_row
            logic [PIX_W-1:0] w_row_in;
            logic [PIX_W-1:0] r_cell [KSIZE];

            if (gi == KSIZE - 1) begin : g_live
                assign w_row_in = pix_data;
            end else begin : g_buf
                assign w_row_in = w_lb_rd[KSIZE-2-gi];
            end

            // Shift this window row by one column per accepted pixel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int c = 0; c < KSIZE; c++) begin
                        r_cell[c] <= '0;
                    end
                end else if (w_accept) begin
                    for (int c = 0; c < KSIZE - 1; c++) begin
                        r_cell[c] <= r_cell[c+1];
                    end
                    r_cell[KSIZE-1] <= w_row_in;
                end
            end

            for (gj = 0; gj < KSIZE; gj++) begin : g_col
                assign win_data[(gi*KSIZE+gj)*PIX_W +: PIX_W] = r_cell[gj];
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_image_window.sv
// Scoreboard bench for param_image_window: a small 3x3/5x4 instance for the
// directed frames and a default 7x7/28x28 instance for a randomized frame.
module tb_param_image_window;

    localparam int WMAX = 7 * 7 * 8;

    logic clk;
    logic rst;
    logic pix_valid;
    logic pix_sof;
    logic win_ready;
    logic [7:0] pix_data;

    logic s_pix_ready, s_win_valid, s_frame_done;
    logic [3*3*8-1:0] s_win_data;
    logic l_pix_ready, l_win_valid, l_frame_done;
    logic [WMAX-1:0] l_win_data;

    int mode;      // 0: small instance observed, 1: large instance observed
    int bp_mode;   // 0: always ready, 1: hold each window 3 cycles, 2: random
    int K, W, H;

    logic d_pix_ready, d_win_valid, d_frame_done;
    logic [WMAX-1:0] d_win_data;

    assign d_pix_ready  = (mode == 1) ? l_pix_ready  : s_pix_ready;
    assign d_win_valid  = (mode == 1) ? l_win_valid  : s_win_valid;
    assign d_frame_done = (mode == 1) ? l_frame_done : s_frame_done;
    assign d_win_data   = (mode == 1) ? l_win_data   : WMAX'(s_win_data);

    param_image_window #(.KSIZE(3), .PIX_W(8), .IMG_W(5), .IMG_H(4)) u_dut_s (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (s_pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .win_valid  (s_win_valid),
        .win_ready  (win_ready),
        .win_data   (s_win_data),
        .frame_done (s_frame_done)
    );

    param_image_window #(.KSIZE(7), .PIX_W(8), .IMG_W(28), .IMG_H(28)) u_dut_l (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (l_pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .win_valid  (l_win_valid),
        .win_ready  (win_ready),
        .win_data   (l_win_data),
        .frame_done (l_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [WMAX-1:0] got, input logic [WMAX-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    logic [WMAX-1:0] sb [$];
    logic [7:0]      img [28][28];
    int              m_r, m_c;
    logic            m_exp_valid, m_fd_exp, m_hold, m_ready, m_q;
    logic [WMAX-1:0] m_hold_data, m_exp_w, m_first, m_last;
    int              m_win_got, m_fd_cnt;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_r = 0; m_c = 0;
            m_exp_valid = 1'b0; m_fd_exp = 1'b0; m_hold = 1'b0;
        end else begin
            m_ready = !m_exp_valid || win_ready;
            if (pix_valid || d_win_valid)
                check_val("pix_ready", d_pix_ready, m_ready);
            if (d_win_valid || m_exp_valid)
                check_val("win_valid", d_win_valid, m_exp_valid);
            if (m_hold)
                check_val("hold_data", d_win_data, m_hold_data);
            if (d_win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_window", d_win_valid, 1'b0);
                end else begin
                    m_exp_w = sb.pop_front();
                    check_val("win_data", d_win_data, m_exp_w);
                    m_win_got++;
                    if (m_win_got == 1) m_first = d_win_data;
                    m_last = d_win_data;
                    $display("window %0d consumed: %0h", m_win_got, d_win_data);
                end
            end
            if (d_frame_done || m_fd_exp)
                check_val("frame_done", d_frame_done, m_fd_exp);
            if (d_frame_done) m_fd_cnt++;
            m_fd_exp = 1'b0;
            m_q = 1'b0;
            if (pix_valid && m_ready) begin
                if (pix_sof) begin
                    m_r = 0; m_c = 0;
                end
                img[m_r][m_c] = pix_data;
                if (m_r >= K - 1 && m_c >= K - 1) begin
                    m_exp_w = '0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            m_exp_w[(i*K+j)*8 +: 8] = img[m_r-K+1+i][m_c-K+1+j];
                    sb.push_back(m_exp_w);
                    m_q = 1'b1;
                end
                if (m_r == H - 1 && m_c == W - 1) m_fd_exp = 1'b1;
                if (m_c == W - 1) begin
                    m_c = 0;
                    m_r = (m_r == H - 1) ? 0 : m_r + 1;
                end else begin
                    m_c++;
                end
            end
            m_hold      = d_win_valid && !win_ready;
            m_hold_data = d_win_data;
            m_exp_valid = m_q || (m_exp_valid && !win_ready);
        end
    end

    // ---------------- downstream ready generator ----------------
    initial begin
        int hold_cnt;
        hold_cnt  = 0;
        win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0: win_ready = 1'b1;
                1: begin
                    if (d_win_valid && hold_cnt < 3) begin
                        win_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        win_ready = 1'b1;
                        hold_cnt  = 0;
                    end
                end
                default: win_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_win_got = 0; m_fd_cnt = 0;
        @(negedge clk);
        check_val("rst_win_valid", d_win_valid, 1'b0);
        check_val("rst_frame_done", d_frame_done, 1'b0);
        check_val("rst_pix_ready", d_pix_ready, 1'b1);
        check_val("rst_win_data", d_win_data, '0);
        @(posedge clk); #1;
    endtask

    task automatic send_px(input logic [7:0] d, input logic sof, input bit gaps);
        bit got;
        got = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
            end
        end
        pix_valid = 1'b1; pix_data = d; pix_sof = sof;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = d_pix_ready;
            @(posedge clk); #1;
        end
        if (!got) check_val("accept_timeout", d_pix_ready, 1'b1);
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int sof_at, input bit gaps);
        int gr, gc;
        logic [7:0] d;
        gr = 0; gc = 0;
        for (int i = 0; i < npix; i++) begin
            if (i == sof_at) begin
                gr = 0; gc = 0;
            end
            d = (mode == 1) ? 8'($urandom) : 8'(gr * 16 + gc);
            send_px(d, (i == sof_at), gaps);
            if (gc == W - 1) begin
                gc = 0;
                gr = (gr == H - 1) ? 0 : gr + 1;
            end else begin
                gc++;
            end
        end
    endtask

    task automatic finish_frame(input int exp_windows, input bit small_pattern);
        logic [71:0] first_c, last_c;
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !d_win_valid;
        end
        if (!done) check_val("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("win_count", m_win_got, exp_windows);
        check_val("frame_done_count", m_fd_cnt, 1);
        if (small_pattern) begin
            first_c = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
            last_c  = {8'h34, 8'h33, 8'h32, 8'h24, 8'h23, 8'h22, 8'h14, 8'h13, 8'h12};
            check_val("first_window", m_first, WMAX'(first_c));
            check_val("last_window", m_last, WMAX'(last_c));
        end
        m_win_got = 0; m_fd_cnt = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        mode = 0; bp_mode = 0; K = 3; W = 5; H = 4;
        m_win_got = 0; m_fd_cnt = 0;
        m_first = '0; m_last = '0;
        do_reset();

        // continuous frame, downstream always ready
        send_frame(20, 0, 1'b0);
        finish_frame(6, 1'b1);

        // same frame with every window held for three cycles
        bp_mode = 1;
        send_frame(20, 0, 1'b0);
        finish_frame(6, 1'b1);
        bp_mode = 0;

        // start-of-frame asserted on the pixel offered at (2,1)
        send_frame(31, 11, 1'b0);
        finish_frame(6, 1'b1);

        // reset while the pixel at (3,1) is about to be offered, then a clean frame
        send_frame(16, 0, 1'b0);
        do_reset();
        send_frame(20, 0, 1'b0);
        finish_frame(6, 1'b1);

        // default-size instance, random valid gaps and random downstream ready
        mode = 1; K = 7; W = 28; H = 28;
        do_reset();
        bp_mode = 2;
        send_frame(784, 0, 1'b1);
        finish_frame(484, 1'b0);
        bp_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_image_window.md
PARAM_IMAGE_WINDOW -- requirements
Module: param_image_window

Interface
REQ-001 The block SHALL have parameter KSIZE, default 7, meaning window side length (odd, 3..7).
REQ-002 The block SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-003 The block SHALL have parameter IMG_W, default 28, meaning image width in pixels (>= KSIZE).
REQ-004 The block SHALL have parameter IMG_H, default 28, meaning image height in pixels (>= KSIZE).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-007 The block SHALL have port pix_valid, input, 1, meaning an input pixel is offered.
REQ-008 The block SHALL have port pix_ready, output, 1, meaning the block accepts a pixel this cycle.
REQ-009 The block SHALL have port pix_data, input, PIX_W, meaning pixel value in raster order.
REQ-010 The block SHALL have port pix_sof, input, 1, meaning the offered pixel is frame position (0,0).
REQ-011 The block SHALL have port win_valid, output, 1, meaning win_data holds a complete window.
REQ-012 The block SHALL have port win_ready, input, 1, meaning the downstream conv block consumes the window.
REQ-013 The block SHALL have port win_data, output, KSIZE*KSIZE*PIX_W, meaning the flattened window; element (r,c) is at bits [(r*KSIZE+c)*PIX_W +: PIX_W], r=0 oldest row, c=0 oldest column.
REQ-014 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 A pixel SHALL be accepted when pix_valid && pix_ready are both high.
REQ-016 pix_ready SHALL equal !win_valid || win_ready (single output stage, combinational from registered state).
REQ-017 Internal counters row (0..IMG_H-1) and col (0..IMG_W-1) SHALL give the position of the next accepted pixel.
REQ-018 On accept, col SHALL increment; at IMG_W-1, col SHALL wrap to 0 and row SHALL increment; at (IMG_H-1, IMG_W-1), both SHALL wrap to 0.
REQ-019 An accepted pixel with pix_sof=1 SHALL be treated as position (0,0), overriding the counters, which then advance from (0,0).
REQ-020 KSIZE-1 line buffers of IMG_W entries SHALL be kept; on accept at column col, LB[0][col]<=pix_data and LB[k][col]<=old LB[k-1][col] (read-before-write).
REQ-021 On accept, every window row SHALL shift left by one column; column KSIZE-1 of row KSIZE-1 SHALL load pix_data, and column KSIZE-1 of row r<KSIZE-1 SHALL load old LB[KSIZE-2-r][col].
REQ-022 win_valid SHALL rise the cycle after accepting a pixel at row>=KSIZE-1 and col>=KSIZE-1 (latency 1).
REQ-023 win_valid SHALL clear after a cycle with win_ready=1 and no new qualifying accept; a simultaneous consume and qualifying accept SHALL keep it high with new data.
REQ-024 While win_valid=1 and win_ready=0, win_data and all internal state SHALL hold.
REQ-025 frame_done SHALL pulse high exactly one cycle after the accept of position (IMG_H-1, IMG_W-1).
REQ-026 Windows SHALL never straddle rows: pixels at col<KSIZE-1 SHALL shift in but SHALL NOT raise win_valid.
REQ-027 Each frame SHALL produce exactly (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1) windows.

Reset
REQ-028 On rst, row, col, win_valid, frame_done and all window registers SHALL be 0; pix_ready SHALL be 1 in the first cycle after reset.
REQ-029 Reset mid-frame SHALL abandon the frame; line buffer contents MAY be left uncleared, since REQ-022 gating prevents stale data reaching a valid window.

Structure
REQ-030 Package sopu_pkg SHALL hold the default KSIZE, PIX_W, IMG_W and IMG_H constants and a pixel_t typedef.
REQ-031 Sub-module line_buffer (depth IMG_W, width PIX_W, read-before-write, shared address) SHALL be instantiated KSIZE-1 times.

Verification
REQ-032 With KSIZE=3, IMG_W=5, IMG_H=4 and pixel value r*16+c streamed continuously (win_ready=1): the first win_valid SHALL occur after pixel (2,2), with win_data = {00,01,02,10,11,12,20,21,22} in element order (0,0)..(2,2).
REQ-033 For the same frame, exactly 6 windows SHALL be produced, the last being rows 1..3 and cols 2..4, and frame_done SHALL pulse once, one cycle after pixel (3,4).
REQ-034 Backpressure: holding win_ready=0 for 3 cycles while win_valid=1 SHALL keep pix_ready=0 and win_data stable; after release, no pixel SHALL be lost or duplicated.
REQ-035 Asserting pix_sof on the pixel offered at position (2,1) SHALL restart counting there as (0,0); no window SHALL appear until the new (2,2).
REQ-036 Asserting rst mid-frame at position (3,1) and then sending a full frame SHALL produce exactly 6 windows, all correct.
REQ-037 With KSIZE=7, IMG_W=IMG_H=28, a random pix_valid/win_ready frame SHALL produce exactly 484 windows, matching a reference model.
